seq_pattern_tx: RTL

//  Serial pattern transmitter: accepts a PAT_W-bit pattern plus a repeat count

---
 rtl/seq_pattern_tx.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// seq_pattern_tx
// ----------------------------------------------------------------------------
// Serial pattern transmitter. A PAT_W-bit pattern and a repeat count are
// loaded over a valid/ready port. The pattern is then shifted out MSB-first,
// one bit per clock, for the requested number of repetitions. Typical use is
// driving the in_seq input of a serial sequence detector (e.g. a "101"
// detector), either on-chip or from a bench.
//
// Parameters
//   PAT_W   pattern width in bits (>= 2)
//   CNT_W   repeat-count width; at most 2**CNT_W-1 repetitions
//
// Ports
//   clk         in   1      clock, all logic on posedge
//   rst         in   1      asynchronous, active-high reset
//   load_valid  in   1      load request
//   load_ready  out  1      high only in IDLE; a load is accepted when
//                           load_valid & load_ready at a posedge
//   load_pat    in   PAT_W  pattern; bit PAT_W-1 is transmitted first
//   load_rep    in   CNT_W  repetitions; 0 is treated as 1
//   abort       in   1      synchronous stop of an active transmission
//   out_seq     out  1      serial data bit (0 whenever out_valid is 0)
//   out_valid   out  1      out_seq carries a pattern bit this cycle
//   busy        out  1      a transmission is in progress (state != IDLE)
//   done        out  1      1-cycle pulse with the final bit of the final rep
//
// Build option
//   SEQ_TX_GAP_EN  when defined, one idle GAP cycle (out_valid=0, busy=1) is
//                  inserted after every non-final repetition. When undefined,
//                  repetitions are sent back-to-back.
//
// All outputs are registered. The next value of every output is derived from
// the next FSM state and next counters, so outputs line up with the state
// they describe without an extra cycle of latency.
// ============================================================================
module seq_pattern_tx #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] load_pat,
    input  logic [CNT_W-1:0] load_rep,
    input  logic             abort,
    output logic             out_seq,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] REP_ZERO = '0;
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SEQ_TX_GAP_EN
    localparam logic [1:0] S_GAP   = 2'd2;
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [IDX_W-1:0] r_bit_idx;   // index of the bit currently on out_seq
    logic [CNT_W-1:0] r_rep_left;  // repetitions left, including the current one

    logic             r_out_seq;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_load_ready;

    // ------------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic [IDX_W-1:0] w_bit_idx_nxt;
    logic [CNT_W-1:0] w_rep_nxt;

    logic             w_last_bit;
    logic             w_last_rep;
    logic             w_accept;
    logic [CNT_W-1:0] w_load_rep_eff;

    logic             w_out_valid_nxt;
    logic             w_out_seq_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_load_ready_nxt;

    assign w_last_bit     = (r_bit_idx == IDX_ZERO);
    // "<=" rather than "==" so a corrupted zero count still terminates.
    assign w_last_rep     = (r_rep_left <= REP_ONE);
    assign w_accept       = load_valid && r_load_ready;
    assign w_load_rep_eff = (load_rep == REP_ZERO) ? REP_ONE : load_rep;

    // ------------------------------------------------------------------------
    // FSM and counter next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_bit_idx_nxt = r_bit_idx;
        w_rep_nxt     = r_rep_left;

        case (r_state)
            S_IDLE: begin
                // abort is ignored in IDLE, so abort+load still loads.
                if (w_accept) begin
                    w_state_nxt   = S_SHIFT;
                    w_pat_nxt     = load_pat;
                    w_bit_idx_nxt = IDX_LAST;
                    w_rep_nxt     = w_load_rep_eff;
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    // When this is the final-bit cycle, the bit and done are
                    // already on the outputs; going IDLE is the same outcome
                    // as a normal finish.
                    w_state_nxt   = S_IDLE;
                    w_bit_idx_nxt = IDX_ZERO;
                    w_rep_nxt     = REP_ZERO;
                end else if (w_last_bit) begin
                    if (w_last_rep) begin
                        w_state_nxt   = S_IDLE;
                        w_bit_idx_nxt = IDX_ZERO;
                        w_rep_nxt     = REP_ZERO;
                    end else begin
                        w_rep_nxt = r_rep_left - REP_ONE;
`ifdef SEQ_TX_GAP_EN
                        // bit_idx stays at 0 through the gap and is
                        // reloaded when SHIFT resumes.
                        w_state_nxt   = S_GAP;
`else
                        w_bit_idx_nxt = IDX_LAST;
`endif
                    end
                end else begin
                    w_bit_idx_nxt = r_bit_idx - IDX_ONE;
                end
            end

`ifdef SEQ_TX_GAP_EN
            S_GAP: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_bit_idx_nxt = IDX_ZERO;
                    w_rep_nxt     = REP_ZERO;
                end else begin
                    w_state_nxt   = S_SHIFT;
                    w_bit_idx_nxt = IDX_LAST;
                end
            end
`endif

            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_idx_nxt = IDX_ZERO;
                w_rep_nxt     = REP_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output next values, derived from the next state so that the registered
    // outputs describe the cycle the FSM is entering.
    // ------------------------------------------------------------------------
    assign w_out_valid_nxt  = (w_state_nxt == S_SHIFT);
    assign w_out_seq_nxt    = w_out_valid_nxt & w_pat_nxt[w_bit_idx_nxt];
    assign w_done_nxt       = w_out_valid_nxt
                              && (w_bit_idx_nxt == IDX_ZERO)
                              && (w_rep_nxt == REP_ONE);
    assign w_busy_nxt       = (w_state_nxt != S_IDLE);
    assign w_load_ready_nxt = (w_state_nxt == S_IDLE);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pat        <= '0;
            r_bit_idx    <= IDX_ZERO;
            r_rep_left   <= REP_ZERO;
            r_out_seq    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_pat        <= w_pat_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_rep_left   <= w_rep_nxt;
            r_out_seq    <= w_out_seq_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_load_ready <= w_load_ready_nxt;
        end
    end

    assign out_seq    = r_out_seq;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule
